// File: rtl/reorder_buffer.sv
// In-order retirement buffer: rename allocates by tag, units write back out of order, one entry retires per cycle.
// Optional performance counters (retired_cnt, flush_cnt) are enabled by defining ROB_PERF_CNT_EN.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic [PREG_W-1:0] alloc_pd_new,
    input  logic [PREG_W-1:0] alloc_pd_old,
    input  logic              alloc_has_rd,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic              wb_mispredict,
    output logic              free_en,
    output logic [PREG_W-1:0] free_preg,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              mispredict,
    output logic              empty,
    output logic              full
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W + 1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W + 1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  misp_q;
    logic [DEPTH-1:0]  has_rd_q;
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;

    logic alloc_fire;
    logic wb_fire;
    logic commit_fire;
    logic flush;

    assign full        = (count_q == FULL_COUNT);
    assign empty       = (count_q == '0);
    assign alloc_ready = !full && !mispredict;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // A writeback racing the allocation of the same tag belongs to the previous occupant, so it is dropped.
    assign wb_fire     = wb_valid && valid_q[wb_tag] && !(alloc_fire && (alloc_tag == wb_tag));
    assign commit_fire = valid_q[head_q] && done_q[head_q];
    assign flush       = commit_fire && misp_q[head_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            misp_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            // Retire the mispredicted entry and squash everything younger, including any same-cycle allocation.
            valid_q <= '0;
            head_q  <= head_q + TAG_ONE;
            tail_q  <= head_q + TAG_ONE;
            count_q <= '0;
        end else begin
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + TAG_ONE;
            end
            if (wb_fire) begin
                done_q[wb_tag] <= 1'b1;
                misp_q[wb_tag] <= wb_mispredict;
            end
            if (alloc_fire) begin
                valid_q[alloc_tag] <= 1'b1;
                done_q[alloc_tag]  <= 1'b0;
                misp_q[alloc_tag]  <= 1'b0;
                tail_q             <= alloc_tag + TAG_ONE;
            end
            if (alloc_fire && !commit_fire) begin
                count_q <= count_q + CNT_ONE;
            end else if (!alloc_fire && commit_fire) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_rd_q[alloc_tag] <= alloc_has_rd;
            pd_new_q[alloc_tag] <= alloc_pd_new;
            pd_old_q[alloc_tag] <= alloc_pd_old;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            free_en      <= 1'b0;
            free_preg    <= '0;
            mispredict   <= 1'b0;
        end else begin
            commit_valid <= commit_fire;
            free_en      <= commit_fire && has_rd_q[head_q];
            free_preg    <= (commit_fire && has_rd_q[head_q]) ? pd_old_q[head_q] : '0;
            mispredict   <= flush;
            if (commit_fire) begin
                commit_tag <= head_q;
            end
        end
    end

    // pd_new and the tail pointer are tracked for recovery and debug; no output consumes them yet.
    logic unused_state;
    assign unused_state = ^{pd_new_q[head_q], tail_q};

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            if (commit_fire) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if (flush) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: per-cycle vector table plus hand sequences, commits checked by an in-order scoreboard.
// Connects the ROB_PERF_CNT_EN counter ports only when that macro is defined.
module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [3:0] alloc_tag;
    logic [6:0] alloc_pd_new;
    logic [6:0] alloc_pd_old;
    logic       alloc_has_rd;
    logic       wb_valid;
    logic [3:0] wb_tag;
    logic       wb_mispredict;
    logic       free_en;
    logic [6:0] free_preg;
    logic       commit_valid;
    logic [3:0] commit_tag;
    logic       mispredict;
    logic       empty;
    logic       full;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [15:0] flush_cnt;
`endif

    reorder_buffer #(.DEPTH(16), .TAG_W(4), .PREG_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .alloc_pd_new (alloc_pd_new),
        .alloc_pd_old (alloc_pd_old),
        .alloc_has_rd (alloc_has_rd),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_mispredict(wb_mispredict),
        .free_en      (free_en),
        .free_preg    (free_preg),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .mispredict   (mispredict),
        .empty        (empty),
        .full         (full)
`ifdef ROB_PERF_CNT_EN
        ,
        .retired_cnt  (retired_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       av;
        logic [3:0] atag;
        logic [6:0] pdo;
        logic       hrd;
        logic       wv;
        logic [3:0] wtag;
        logic       wm;
        logic       acc;
        logic       chk;
        logic       e_empty;
        logic       e_full;
        logic       e_ready;
        logic       e_commit;
    } vec_t;

    typedef struct {
        logic [3:0] tag;
        logic       fe;
        logic [6:0] fp;
        logic       misp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[15];

    task automatic checkBit(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, req);
        end
    endtask

    task automatic checkNum(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every retire must match the oldest outstanding allocation; a mispredicted retire squashes the rest.
    always @(negedge clk) begin
        exp_t e;
        logic exp_m;
        exp_m = 1'b0;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (commit_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL commit_unexpected: got tag %0d expected no commit", commit_tag);
                end else begin
                    e = exp_q.pop_front();
                    checkNum("commit_tag", int'(commit_tag), int'(e.tag));
                    checkBit("free_en", free_en, e.fe);
                    checkNum("free_preg", int'(free_preg), int'(e.fp));
                    exp_m = e.misp;
                    if (e.misp) exp_q.delete();
                end
            end else if (free_en) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL free_without_commit: got free_en 1 expected 0");
            end
            if (mispredict || exp_m) checkBit("mispredict_pulse", mispredict, exp_m);
        end
    end

    function automatic vec_t row(input logic rst, input logic av, input int atag, input int pdo,
                                 input logic hrd, input logic wv, input int wtag, input logic wm,
                                 input logic acc, input logic chk, input logic ee, input logic ef,
                                 input logic er, input logic ec);
        vec_t v;
        v.rst = rst;  v.av = av;  v.atag = 4'(atag);  v.pdo = 7'(pdo);
        v.hrd = hrd;  v.wv = wv;  v.wtag = 4'(wtag);  v.wm = wm;
        v.acc = acc;  v.chk = chk;
        v.e_empty = ee;  v.e_full = ef;  v.e_ready = er;  v.e_commit = ec;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        reset         = v.rst;
        alloc_valid   = v.av;
        alloc_tag     = v.atag;
        alloc_pd_old  = v.pdo;
        alloc_pd_new  = v.pdo ^ 7'h40;
        alloc_has_rd  = v.hrd;
        wb_valid      = v.wv;
        wb_tag        = v.wtag;
        wb_mispredict = v.wm;
        if (v.av && v.acc) begin
            e.tag  = v.atag;
            e.fe   = v.hrd;
            e.fp   = v.hrd ? v.pdo : 7'd0;
            e.misp = 1'b0;
            exp_q.push_back(e);
        end
        if (v.wv && v.wm) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].tag == v.wtag) begin
                    e = exp_q[i];
                    e.misp = 1'b1;
                    exp_q[i] = e;
                end
            end
        end
        step();
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        if (v.chk) begin
            checkBit($sformatf("row%0d_empty", idx), empty, v.e_empty);
            checkBit($sformatf("row%0d_full", idx), full, v.e_full);
            checkBit($sformatf("row%0d_alloc_ready", idx), alloc_ready, v.e_ready);
            checkBit($sformatf("row%0d_commit_valid", idx), commit_valid, v.e_commit);
        end
    endtask

    task automatic cyc(input logic av, input int atag, input int pdo, input logic hrd, input logic acc,
                       input logic wv, input int wtag, input logic wm);
        applyStimulus(row(1'b0, av, atag, pdo, hrd, wv, wtag, wm, acc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic doReset();
        applyStimulus(row(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic drainWait(input int budget, input string name);
        int n;
        idle();
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checkNum({name, "_drained"}, exp_q.size(), 0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        //            rst av tag pdo hrd wv wtg wm  acc chk  emp ful rdy cmt
        tbl[0]  = row(0, 1, 0,  5, 1,  0, 0, 0,  1, 1,  0, 0, 1, 0);
        tbl[1]  = row(0, 0, 0,  0, 0,  1, 0, 0,  0, 1,  0, 0, 1, 0);
        tbl[2]  = row(0, 0, 0,  0, 0,  0, 0, 0,  0, 1,  1, 0, 1, 1);
        tbl[3]  = row(0, 0, 0,  0, 0,  0, 0, 0,  0, 1,  1, 0, 1, 0);
        tbl[4]  = row(1, 0, 0,  0, 0,  0, 0, 0,  0, 1,  1, 0, 1, 0);
        tbl[5]  = row(0, 1, 0, 20, 1,  0, 0, 0,  1, 1,  0, 0, 1, 0);
        tbl[6]  = row(0, 1, 1, 21, 0,  0, 0, 0,  1, 1,  0, 0, 1, 0);
        tbl[7]  = row(0, 1, 2, 22, 1,  0, 0, 0,  1, 1,  0, 0, 1, 0);
        tbl[8]  = row(0, 0, 0,  0, 0,  1, 2, 0,  0, 1,  0, 0, 1, 0);
        tbl[9]  = row(0, 0, 0,  0, 0,  1, 1, 0,  0, 1,  0, 0, 1, 0);
        tbl[10] = row(0, 0, 0,  0, 0,  1, 0, 0,  0, 1,  0, 0, 1, 0);
        tbl[11] = row(0, 0, 0,  0, 0,  0, 0, 0,  0, 1,  0, 0, 1, 1);
        tbl[12] = row(0, 0, 0,  0, 0,  0, 0, 0,  0, 1,  0, 0, 1, 1);
        tbl[13] = row(0, 0, 0,  0, 0,  0, 0, 0,  0, 1,  1, 0, 1, 1);
        tbl[14] = row(0, 0, 0,  0, 0,  0, 0, 0,  0, 1,  1, 0, 1, 0);

        reset = 1'b1;
        alloc_valid = 1'b0; alloc_tag = '0; alloc_pd_new = '0; alloc_pd_old = '0; alloc_has_rd = 1'b0;
        wb_valid = 1'b0; wb_tag = '0; wb_mispredict = 1'b0;
        step();
        step();
        reset = 1'b0;
        checkBit("reset_empty", empty, 1'b1);
        checkBit("reset_full", full, 1'b0);
        checkBit("reset_alloc_ready", alloc_ready, 1'b1);
        checkBit("reset_commit_valid", commit_valid, 1'b0);
        checkBit("reset_free_en", free_en, 1'b0);
        checkBit("reset_mispredict", mispredict, 1'b0);
        checkNum("reset_free_preg", int'(free_preg), 0);
        checkNum("reset_commit_tag", int'(commit_tag), 0);

        $display("[TB] vector table: single retire latency and out-of-order writeback");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], i);
        end
        drainWait(10, "table");

        $display("[TB] fill to full, refuse at full, resume after one retire");
        doReset();
        for (int i = 0; i < 16; i++) cyc(1'b1, i, 32 + i, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        checkBit("fill_full", full, 1'b1);
        checkBit("fill_alloc_ready", alloc_ready, 1'b0);
        checkBit("fill_empty", empty, 1'b0);
        cyc(1'b1, 0, 99, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        checkBit("fill_full_hold", full, 1'b1);
        cyc(1'b1, 0, 99, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkBit("fill_commit_one", commit_valid, 1'b1);
        checkBit("fill_not_full", full, 1'b0);
        checkBit("fill_ready_again", alloc_ready, 1'b1);
        cyc(1'b1, 0, 77, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        checkBit("fill_refull", full, 1'b1);
        for (int i = 1; i <= 16; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, i % 16, 1'b0);
        drainWait(40, "fill");

        $display("[TB] mispredicted branch flushes younger entries");
        doReset();
        cyc(1'b1, 0, 40, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1, 41, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 2, 42, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 3, 43, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checkNum("flush_first_commit", int'(commit_tag), 0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checkBit("flush_pulse", mispredict, 1'b1);
        checkBit("flush_empty", empty, 1'b1);
        checkBit("flush_alloc_ready", alloc_ready, 1'b0);
        cyc(1'b1, 2, 50, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkBit("flush_pulse_once", mispredict, 1'b0);
        checkBit("flush_alloc_blocked", empty, 1'b1);
        cyc(1'b1, 2, 60, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        drainWait(10, "flush");

        $display("[TB] pointer wrap across tag 15 to tag 0");
        doReset();
        for (int i = 0; i < 13; i++) cyc(1'b1, i, 64 + i, (i % 2) == 0, 1'b1, i > 0, (i > 0) ? i - 1 : 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 12, 1'b0);
        drainWait(10, "advance");
        cyc(1'b1, 13, 100, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 14, 101, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 15, 102, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 0, 103, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 15, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 14, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 13, 1'b0);
        drainWait(10, "wrap");

        $display("[TB] writeback racing allocation of the same tag is dropped");
        cyc(1'b1, 1, 110, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) step();
        checkBit("same_tag_wb_dropped", empty, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        drainWait(10, "same_tag");

        $display("[TB] reset with entries in flight");
        doReset();
        for (int i = 0; i < 5; i++) cyc(1'b1, i, 120 + i, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 1; i < 5; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, i, 1'b0);
        checkBit("inflight_not_empty", empty, 1'b0);
        doReset();
        checkBit("inflight_reset_empty", empty, 1'b1);
        checkBit("inflight_reset_full", full, 1'b0);
        checkBit("inflight_reset_commit", commit_valid, 1'b0);
        checkBit("inflight_reset_free", free_en, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (commit_valid || free_en) pulses++;
        end
        checkNum("inflight_no_pulses", pulses, 0);
        checkBit("inflight_still_empty", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of ROB entries; power of two.
REQ-002 SHALL have parameter TAG_W, default 4, tag width, equal to log2(DEPTH).
REQ-003 SHALL have parameter PREG_W, default 7, physical register index width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 alloc_valid  input  1  rename stage presents an instruction.
REQ-007 alloc_ready  output  1  ROB accepts an allocation this cycle.
REQ-008 alloc_tag  input  TAG_W  ROB tag assigned by rename.
REQ-009 alloc_pd_new  input  PREG_W  newly mapped physical destination.
REQ-010 alloc_pd_old  input  PREG_W  previous mapping of rd; freed at commit.
REQ-011 alloc_has_rd  input  1  instruction writes a destination (not a store, rd != x0).
REQ-012 wb_valid  input  1  functional unit completion strobe.
REQ-013 wb_tag  input  TAG_W  tag of the completing instruction.
REQ-014 wb_mispredict  input  1  completing branch resolved mispredicted.
REQ-015 free_en  output  1  registered one-cycle pulse returning free_preg to the free list.
REQ-016 free_preg  output  PREG_W  physical register being freed (pd_old of the retired entry).
REQ-017 commit_valid  output  1  registered one-cycle pulse per retired instruction.
REQ-018 commit_tag  output  TAG_W  tag of the retired instruction.
REQ-019 mispredict  output  1  registered one-cycle flush pulse to rename, map table and free list.
REQ-020 empty, full  output  1 each  occupancy flags; combinational from count.

Function
REQ-021 Storage per entry: valid, done, mispredicted, has_rd, pd_new, pd_old; head and tail pointers of TAG_W bits; count of TAG_W+1 bits.
REQ-022 alloc_ready = !full && !mispredict.
REQ-023 Allocate on alloc_valid && alloc_ready: entry[alloc_tag] set valid, done=0, mispredicted=0, fields captured; tail := alloc_tag+1 mod DEPTH; count += 1.
REQ-024 Rename issues tags in order; alloc_tag != tail is a protocol violation, with undefined behaviour.
REQ-025 Writeback: wb_valid with entry[wb_tag].valid sets done=1 and mispredicted=wb_mispredict; a writeback to an invalid entry is ignored.
REQ-026 A writeback and an allocation of the same tag in the same cycle: the allocation wins and the writeback is dropped.
REQ-027 Commit: one entry per cycle, when entry[head].valid && done; clear valid, head += 1 mod DEPTH, count -= 1.
REQ-028 On commit: next cycle commit_valid=1, commit_tag=head, free_en=has_rd, free_preg=has_rd ? pd_old : 0.
REQ-029 Simultaneous allocation and commit: count unchanged; allocation is permitted at full only if alloc_ready is already high (never at full).
REQ-030 Latency: allocation in cycle N, earliest writeback N+1, earliest commit decision N+2, outputs visible N+3.
REQ-031 Commit of an entry with mispredicted=1 is a normal retire and, in addition, asserts mispredict for exactly one cycle in the following cycle.
REQ-032 Same edge as that retire: all entries invalidated, tail := head+1, count := 0; no allocations during the mispredict cycle.
REQ-033 Pointers wrap modulo DEPTH; tag 15 is followed by tag 0.

Reset
REQ-034 Reset clears all valid bits, head=tail=0, count=0.
REQ-035 Reset drives free_en, commit_valid and mispredict to 0, and free_preg and commit_tag to 0.
REQ-036 Reset asserted mid-operation discards all in-flight entries with no free pulses.

Configuration
REQ-037 Macro ROB_PERF_CNT_EN: when defined, adds output retired_cnt (32 bits, reset 0) incrementing on each commit and output flush_cnt (16 bits, reset 0) incrementing on each mispredict; both wrap.
REQ-038 When ROB_PERF_CNT_EN is not defined, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-039 Reset, allocate tag 0 (pd_old=5, has_rd=1), writeback tag 0 the next cycle -> commit_valid and free_en with free_preg=5 exactly 3 cycles after allocation.
REQ-040 Allocate 16 entries without writeback -> full=1, alloc_ready=0; then writeback tag 0 -> one commit, and allocation resumes the cycle after.
REQ-041 Writebacks out of order for tags 2,1,0 -> commits in order 0,1,2 on consecutive cycles.
REQ-042 Allocate tags 0-3, with tag 1 a branch; writeback tag 1 mispredicted, then tag 0 -> commits 0 and 1, mispredict pulses once, empty=1, tail=2, and tags 2-3 are never committed.
REQ-043 Allocate tags 13,14,15,0 after a pointer advance -> wrap-around commits with correct order and tags.
REQ-044 Assert reset with 5 entries in flight -> empty=1, and no free_en or commit_valid pulses afterwards.
